// File: rtl/pc_next_unit.sv
// Next-PC generator: prioritised redirect select, PC register, and one-deep buffer for redirects seen during stall.
// Optional target alignment check is enabled by defining PC_ALIGN_CHECK_EN.
module pc_next_unit #(
    parameter int              WIDTH    = 32,
    parameter int              NSRC     = 4,
    parameter int              INC      = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 'h0000_3000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic [NSRC-1:0]            req,
    input  logic [NSRC*WIDTH-1:0]      tgt,
    output logic [WIDTH-1:0]           pc,
    output logic                       pc_valid,
    output logic [$clog2(NSRC+1)-1:0]  sel,
    output logic                       redirect_taken,
    output logic                       pend,
    output logic                       misalign
);

    localparam int SW = $clog2(NSRC + 1);

    logic [WIDTH-1:0] tgt_arr [NSRC];
    logic             any_req;
    logic [SW-1:0]    win_sel;
    logic [WIDTH-1:0] win_tgt;
    logic [SW-1:0]    load_sel;
    logic [WIDTH-1:0] load_tgt;
    logic [WIDTH-1:0] load_pc;

    logic [WIDTH-1:0] pc_reg;
    logic             pc_valid_reg;
    logic [SW-1:0]    sel_reg;
    logic             redirect_taken_reg;
    logic             pend_reg;
    logic [WIDTH-1:0] pend_tgt_reg;
    logic [SW-1:0]    pend_sel_reg;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_unpack
            assign tgt_arr[gi] = tgt[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Ascending scan so the highest requesting index wins.
    always_comb begin
        any_req = |req;
        win_sel = '0;
        win_tgt = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (req[k]) begin
                win_sel = SW'(k + 1);
                win_tgt = tgt_arr[k];
            end
        end
    end

    // Pending selector is stored as index+1 so NSRC=1 needs no zero-width field.
    always_comb begin
        load_tgt = any_req ? win_tgt : pend_tgt_reg;
        load_sel = any_req ? win_sel : pend_sel_reg;
`ifdef PC_ALIGN_CHECK_EN
        load_pc  = {load_tgt[WIDTH-1:2], 2'b00};
`else
        load_pc  = load_tgt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg             <= RESET_PC;
            pc_valid_reg       <= 1'b0;
            sel_reg            <= '0;
            redirect_taken_reg <= 1'b0;
            pend_reg           <= 1'b0;
            pend_tgt_reg       <= '0;
            pend_sel_reg       <= '0;
        end else begin
            pc_valid_reg <= 1'b1;
            if (stall) begin
                sel_reg            <= '0;
                redirect_taken_reg <= 1'b0;
                if (any_req) begin
                    pend_reg     <= 1'b1;
                    pend_tgt_reg <= win_tgt;
                    pend_sel_reg <= win_sel;
                end
            end else if (any_req || pend_reg) begin
                pc_reg             <= load_pc;
                sel_reg            <= load_sel;
                redirect_taken_reg <= 1'b1;
                pend_reg           <= 1'b0;
            end else begin
                pc_reg             <= pc_reg + WIDTH'(INC);
                sel_reg            <= '0;
                redirect_taken_reg <= 1'b0;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_reg <= 1'b0;
        end else if (stall) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= (any_req || pend_reg) && (|load_tgt[1:0]);
        end
    end

    assign misalign = misalign_reg;
`else
    assign misalign = 1'b0;
`endif

    assign pc             = pc_reg;
    assign pc_valid       = pc_valid_reg;
    assign sel            = sel_reg;
    assign redirect_taken = redirect_taken_reg;
    assign pend           = pend_reg;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: a behavioural model pushes expected outputs per edge,
// which are popped and compared after the edge; directed checks cover the listed scenarios.
module tb_pc_next_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall;
    logic [3:0]   req;
    logic [127:0] tgt;
    logic [31:0]  pc;
    logic         pc_valid;
    logic [2:0]   sel;
    logic         redirect_taken;
    logic         pend;
    logic         misalign;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [2:0]  sel;
        logic        rt;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_pc;
    logic        m_valid;
    logic [2:0]  m_sel;
    logic        m_rt;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic [2:0]  m_psel;
    logic        m_mis;

    pc_next_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .req            (req),
        .tgt            (tgt),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .sel            (sel),
        .redirect_taken (redirect_taken),
        .pend           (pend),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_valid = 1'b0; m_sel = 3'd0; m_rt = 1'b0;
        m_pend = 1'b0; m_ptgt = 32'h0; m_psel = 3'd0; m_mis = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic [2:0]  ws;
        logic [31:0] wt;
        logic [31:0] lt;
        exp_t        e;
        ws = 3'd0;
        wt = 32'h0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                ws = 3'(k + 1);
                wt = tgt[k*32 +: 32];
                break;
            end
        end
        m_valid = 1'b1;
        if (stall) begin
            m_sel = 3'd0; m_rt = 1'b0; m_mis = 1'b0;
            if (ws != 3'd0) begin
                m_pend = 1'b1; m_ptgt = wt; m_psel = ws;
            end
        end else if (ws != 3'd0 || m_pend) begin
            lt = (ws != 3'd0) ? wt : m_ptgt;
            m_sel = (ws != 3'd0) ? ws : m_psel;
            m_rt = 1'b1;
            m_pend = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            m_mis = (lt[1:0] != 2'b00);
            m_pc = lt & 32'hFFFF_FFFC;
`else
            m_mis = 1'b0;
            m_pc = lt;
`endif
        end else begin
            m_pc = m_pc + 32'd4;
            m_sel = 3'd0; m_rt = 1'b0; m_mis = 1'b0;
        end
        e.pc = m_pc; e.valid = m_valid; e.sel = m_sel; e.rt = m_rt; e.pend = m_pend; e.mis = m_mis;
        exp_q.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_valid", 32'(pc_valid), 32'(e.valid));
        check("sb_sel", 32'(sel), 32'(e.sel));
        check("sb_rt", 32'(redirect_taken), 32'(e.rt));
        check("sb_pend", 32'(pend), 32'(e.pend));
        check("sb_mis", 32'(misalign), 32'(e.mis));
        $display("txn stall=%0b req=%b pc=%h sel=%0d rt=%0b pend=%0b mis=%0b",
                 stall, req, pc, sel, redirect_taken, pend, misalign);
    endtask

    task automatic step(input logic s, input logic [3:0] r, input logic [127:0] t);
        stall = s;
        req   = r;
        tgt   = t;
        model_edge();
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, pc, 32'h0000_3000);
        check({tag, "_valid"}, 32'(pc_valid), 32'd0);
        check({tag, "_sel"}, 32'(sel), 32'd0);
        check({tag, "_rt"}, 32'(redirect_taken), 32'd0);
        check({tag, "_pend"}, 32'(pend), 32'd0);
        check({tag, "_mis"}, 32'(misalign), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        req   = 4'b0;
        tgt   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst_n = 1'b1;

        // Sequential fetch after release.
        step(1'b0, 4'b0000, '0);
        check("t1_pc0", pc, 32'h0000_3004);
        step(1'b0, 4'b0000, '0);
        check("t1_pc1", pc, 32'h0000_3008);

        // Priority: source 2 beats source 1.
        step(1'b0, 4'b0110, {32'h0, 32'h200, 32'h100, 32'h0});
        check("t2_pc", pc, 32'h0000_0200);
        check("t2_sel", 32'(sel), 32'd3);
        check("t2_rt", 32'(redirect_taken), 32'd1);
        step(1'b0, 4'b0000, '0);
        check("t2_seq", pc, 32'h0000_0204);

        // Redirect buffered during stall, applied on release.
        step(1'b1, 4'b0001, {96'h0, 32'h400});
        check("t3_hold", pc, 32'h0000_0204);
        check("t3_pend", 32'(pend), 32'd1);
        step(1'b1, 4'b0000, '0);
        step(1'b1, 4'b0000, '0);
        step(1'b0, 4'b0000, '0);
        check("t3_pc", pc, 32'h0000_0400);
        check("t3_sel", 32'(sel), 32'd1);
        check("t3_pend0", 32'(pend), 32'd0);

        // New request on release beats the pending one.
        step(1'b1, 4'b0001, {96'h0, 32'h400});
        step(1'b0, 4'b1000, {32'h800, 96'h0});
        check("t4_pc", pc, 32'h0000_0800);
        check("t4_sel", 32'(sel), 32'd4);
        step(1'b0, 4'b0000, '0);
        check("t4_seq", pc, 32'h0000_0804);

        // Wrap at all-ones, then asynchronous reset clears a pending redirect.
        step(1'b0, 4'b0001, {96'h0, 32'hFFFF_FFFC});
        step(1'b0, 4'b0000, '0);
        check("t5_wrap", pc, 32'h0000_0000);
        step(1'b1, 4'b0010, {64'h0, 32'h500, 32'h0});
        check("t5_pend", 32'(pend), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("t5_arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 4'b0000, '0);
        check("t5_after", pc, 32'h0000_3004);

        // Unaligned target.
        step(1'b0, 4'b0010, {64'h0, 32'h1002, 32'h0});
`ifdef PC_ALIGN_CHECK_EN
        check("t6_pc", pc, 32'h0000_1000);
        check("t6_mis", 32'(misalign), 32'd1);
`else
        check("t6_pc", pc, 32'h0000_1002);
        check("t6_mis", 32'(misalign), 32'd0);
`endif
        step(1'b0, 4'b0000, '0);
        check("t6_mis0", 32'(misalign), 32'd0);

        // Random mix of stalls, requests and unaligned targets.
        for (int i = 0; i < 300; i++) begin
            logic [127:0] rt;
            logic [3:0]   rr;
            rt = {$urandom, $urandom, $urandom, $urandom};
            rr = ($urandom_range(0, 2) == 0) ? 4'(($urandom)) : 4'b0000;
            step(($urandom_range(0, 3) == 0), rr, rt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
